// File: rtl/c5x7_pkg.sv
// Shared constants and state type for the c5x7 convolver front-end sequencer.
package c5x7_pkg;
  localparam int NTAPS    = 35;
  localparam int SW       = 40;
  localparam int WW       = 33;
  localparam int AW       = 6;
  localparam int WQ_DEPTH = 4;
  localparam int CNTW     = 16;
  localparam int IDXW     = 6;
  localparam int QCW      = $clog2(WQ_DEPTH) + 1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NTAPS - 1);

  typedef enum logic [1:0] {FILL, DRAIN, PUSH} state_t;
endpackage

// File: rtl/c5x7_wq.sv
// Synchronous FIFO holding pending coefficient writes {addr, data}.
module c5x7_wq #(
  parameter int DEPTH = 4,
  parameter int W     = 39
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
endmodule

// File: rtl/c5x7_seq.sv
// Window assembler and fenced coefficient-write sequencer feeding the c5x7 convolver.
module c5x7_seq
  import c5x7_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wv,
  input  logic [AW-1:0]          wa,
  input  logic [WW-1:0]          wd,
  output logic                   wrdy,
  input  logic                   sv,
  input  logic signed [SW-1:0]   sd,
  output logic                   srdy,
  output logic [AW-1:0]          ca,
  output logic [WW-1:0]          cd,
  output logic                   cw,
  output logic                   push_samp,
  output logic [NTAPS*SW-1:0]    samp,
  input  logic                   pushout,
  output logic [CNTW-1:0]        win_cnt,
  output logic [CNTW-1:0]        res_cnt,
  output logic                   err_addr
);
  state_t            state, state_nx;
  logic [IDXW-1:0]   idx;
  logic [QCW-1:0]    fence, fence_nx;
  logic [QCW-1:0]    q_cnt, q_after;
  logic              q_full, q_empty, q_push, q_pop;
  logic [AW+WW-1:0]  q_dout;
  logic              w_acc, w_ok, s_acc, last_samp;
  logic              issue_en, issue;
  logic [AW-1:0]     iss_a;
  logic [WW-1:0]     iss_d;

  c5x7_wq #(
    .DEPTH (WQ_DEPTH),
    .W     (AW + WW)
  ) u_wq (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .din   ({wa, wd}),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_cnt)
  );

  assign wrdy      = !q_full;
  assign srdy      = (state == FILL);
  assign w_acc     = wv && wrdy;
  assign w_ok      = w_acc && (wa <= LAST_ADDR);
  assign s_acc     = sv && srdy;
  assign last_samp = s_acc && (idx == IDXW'(NTAPS - 1));

  // An issue lands on cw one cycle later, so nothing may issue in the cycle
  // before PUSH; that is the zero-fence DRAIN cycle or the forced DRAIN below.
  always_comb begin
    issue_en = 1'b0;
    state_nx = state;
    fence_nx = fence;
    case (state)
      FILL:    issue_en = 1'b1;
      DRAIN:   issue_en = (fence != '0);
      PUSH:    issue_en = 1'b1;
      default: issue_en = 1'b0;
    endcase

    // An empty queue lets an incoming legal write go straight out.
    issue   = issue_en && (!q_empty || w_ok);
    q_pop   = issue && !q_empty;
    q_push  = w_ok && !(issue && q_empty);
    {iss_a, iss_d} = q_empty ? {wa, wd} : q_dout;
    q_after = q_cnt + QCW'(q_push) - QCW'(q_pop);

    case (state)
      FILL: begin
        if (last_samp) begin
          fence_nx = q_after;
          state_nx = (q_after != '0 || issue) ? DRAIN : PUSH;
        end
      end
      DRAIN: begin
        if (fence == '0)  state_nx = PUSH;
        else if (issue)   fence_nx = fence - 1'b1;
      end
      PUSH:    state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  // Control and write-port registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      fence     <= '0;
      idx       <= '0;
      cw        <= 1'b0;
      ca        <= '0;
      cd        <= '0;
      push_samp <= 1'b0;
      win_cnt   <= '0;
      res_cnt   <= '0;
      err_addr  <= 1'b0;
    end else begin
      state     <= state_nx;
      fence     <= fence_nx;
      cw        <= issue;
      push_samp <= (state_nx == PUSH);
      if (issue) begin
        ca <= iss_a;
        cd <= iss_d;
      end
      if (last_samp)  idx <= '0;
      else if (s_acc) idx <= idx + 1'b1;
      if (state_nx == PUSH) win_cnt <= win_cnt + 1'b1;
      if (pushout)          res_cnt <= res_cnt + 1'b1;
      if (w_acc && !w_ok)   err_addr <= 1'b1;
    end
  end

  // Window register file: slots are overwritten in place as samples arrive
  always_ff @(posedge clk) begin
    if (reset) begin
      samp <= '0;
    end else begin
      for (int i = 0; i < NTAPS; i++) begin
        if (s_acc && idx == IDXW'(i)) samp[i*SW +: SW] <= sd;
      end
    end
  end
endmodule

// File: tb/tb_c5x7_seq.sv
// Randomized, model-checked bench for c5x7_seq with directed window/write scenarios.
module tb_c5x7_seq;
  logic                clk = 1'b0;
  logic                reset, wv, sv, pushout;
  logic [5:0]          wa;
  logic [32:0]         wd;
  logic signed [39:0]  sd;
  logic                wrdy, srdy, cw, push_samp, err_addr;
  logic [5:0]          ca;
  logic [32:0]         cd;
  logic [1399:0]       samp;
  logic [15:0]         win_cnt, res_cnt;

  c5x7_seq dut (
    .clk(clk), .reset(reset), .wv(wv), .wa(wa), .wd(wd), .wrdy(wrdy),
    .sv(sv), .sd(sd), .srdy(srdy), .ca(ca), .cd(cd), .cw(cw),
    .push_samp(push_samp), .samp(samp), .pushout(pushout),
    .win_cnt(win_cnt), .res_cnt(res_cnt), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Behavioural reference: pending writes as a queue, window as an array.
  logic [38:0]        mq[$];
  logic signed [39:0] mwin [35];
  int                 m_nsamp, m_mode, m_fence;   // mode 0 collect, 1 drain, 2 push
  logic               m_cw, m_push, m_err;
  logic [5:0]         m_ca;
  logic [32:0]        m_cd;
  logic [15:0]        m_win, m_res;

  typedef struct { int c; logic [5:0] a; logic [32:0] d; } cwev_t;
  cwev_t         cw_log[$];
  int            push_log[$];
  logic [1399:0] last_push_samp;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    int  f0;
    int  pre;
    bit  issued;
    bit  can;
    bit  got;
    if (reset) begin
      mq.delete();
      for (int i = 0; i < 35; i++) mwin[i] = '0;
      m_nsamp = 0; m_mode = 0; m_fence = 0;
      m_cw = 0; m_push = 0; m_err = 0; m_ca = '0; m_cd = '0; m_win = '0; m_res = '0;
    end else begin
      f0  = m_fence;
      pre = mq.size();
      can = (m_mode != 1) || (f0 > 0);
      got = sv && (m_mode == 0);
      if (wv && pre < 4) begin
        if (wa > 6'd34) m_err = 1'b1;
        else            mq.push_back({wa, wd});
      end
      issued = 0;
      m_cw   = 0;
      if (can && mq.size() > 0) begin
        {m_ca, m_cd} = mq.pop_front();
        m_cw   = 1;
        issued = 1;
      end
      case (m_mode)
        0: if (got) begin
             mwin[m_nsamp] = sd;
             m_nsamp++;
             if (m_nsamp == 35) begin
               m_nsamp = 0;
               m_fence = mq.size();
               m_mode  = (m_fence > 0 || issued) ? 1 : 2;
             end
           end
        1: if (f0 == 0) m_mode = 2;
           else if (issued) m_fence--;
        default: m_mode = 0;
      endcase
      m_push = (m_mode == 2);
      if (m_push) m_win = m_win + 16'd1;
      if (pushout) m_res = m_res + 16'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic drive(input bit s, input logic [39:0] d, input bit w,
                       input logic [5:0] a, input logic [32:0] dd);
    sv = s; sd = d; wv = w; wa = a; wd = dd;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, '0);
  endtask

  function automatic int push_at(input int i);
    return (push_log.size() > i) ? push_log[i] : -1;
  endfunction

  // Per-cycle compare against the model, plus event logs for directed pins.
  initial begin
    logic [1399:0] exp_flat;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 35; i++) exp_flat[i*40 +: 40] = mwin[i];
        chk("srdy", 64'(srdy), 64'(m_mode == 0));
        chk("wrdy", 64'(wrdy), 64'(mq.size() < 4));
        chk("cw", 64'(cw), 64'(m_cw));
        chk("ca", 64'(ca), 64'(m_ca));
        chk("cd", 64'(cd), 64'(m_cd));
        chk("push_samp", 64'(push_samp), 64'(m_push));
        chk("win_cnt", 64'(win_cnt), 64'(m_win));
        chk("res_cnt", 64'(res_cnt), 64'(m_res));
        chk("err_addr", 64'(err_addr), 64'(m_err));
        checks++;
        if (samp !== exp_flat) begin
          failures++;
          for (int i = 0; i < 35; i++)
            if (samp[i*40 +: 40] !== exp_flat[i*40 +: 40]) begin
              $display("FAIL samp slot=%0d cyc=%0d actual=%0h required=%0h",
                       i, cyc, samp[i*40 +: 40], exp_flat[i*40 +: 40]);
              break;
            end
        end
        if (push_samp) begin
          push_log.push_back(cyc);
          last_push_samp = samp;
        end
        if (cw) cw_log.push_back('{cyc, ca, cd});
      end
    end
  end

  initial begin
    int k34;
    int bad;
    reset = 1'b1; wv = 0; sv = 0; pushout = 0; wa = '0; wd = '0; sd = '0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_push", 64'(push_samp), 64'd0);
    chk("rst_cw", 64'(cw), 64'd0);
    chk("rst_win", 64'(win_cnt), 64'd0);
    chk("rst_samp_zero", 64'(samp == '0), 64'd1);
    idle(2);

    // Window 1: samples i+1, no writes.
    cw_log.delete(); push_log.delete();
    for (int i = 0; i < 35; i++) begin
      if (i == 34) k34 = cyc;
      drive(1'b1, 40'(i + 1), 1'b0, '0, '0);
    end
    sv = 0;
    chk("w1_srdy_push_cycle", 64'(srdy), 64'd0);
    tick();
    chk("w1_srdy_back", 64'(srdy), 64'd1);
    idle(3);
    chk("w1_push_cycle", 64'(push_at(0)), 64'(k34 + 1));
    chk("w1_push_count", 64'(push_log.size()), 64'd1);
    chk("w1_no_cw", 64'(cw_log.size()), 64'd0);
    bad = 0;
    for (int i = 0; i < 35; i++)
      if (last_push_samp[i*40 +: 40] !== 40'(i + 1)) bad++;
    chk("w1_slots", 64'(bad), 64'd0);
    chk("w1_win_cnt", 64'(win_cnt), 64'd1);

    // Window 2: writes during sample 10 and sample 34 must land before the push.
    cw_log.delete(); push_log.delete();
    for (int i = 0; i < 35; i++) begin
      if (i == 34) k34 = cyc;
      if (i == 10)      drive(1'b1, 40'(200 + i), 1'b1, 6'd3, 33'h1_0000_0005);
      else if (i == 34) drive(1'b1, 40'(200 + i), 1'b1, 6'd34, 33'h7);
      else              drive(1'b1, 40'(200 + i), 1'b0, '0, '0);
    end
    idle(4);
    chk("w2_cw_count", 64'(cw_log.size()), 64'd2);
    if (cw_log.size() == 2) begin
      chk("w2_first_ca", 64'(cw_log[0].a), 64'd3);
      chk("w2_first_cd", 64'(cw_log[0].d), 64'h1_0000_0005);
      chk("w2_second_ca", 64'(cw_log[1].a), 64'd34);
      chk("w2_second_cd", 64'(cw_log[1].d), 64'h7);
      chk("w2_second_before_push", 64'(cw_log[1].c < push_at(0)), 64'd1);
    end
    chk("w2_push_delayed", 64'(push_at(0)), 64'(k34 + 2));

    // Illegal address is dropped and flagged; the next legal write still goes out.
    cw_log.delete();
    bad = cyc;
    drive(1'b0, '0, 1'b1, 6'd40, 33'h5);
    drive(1'b0, '0, 1'b1, 6'd0, 33'h9);
    idle(3);
    chk("bad_err_sticky", 64'(err_addr), 64'd1);
    chk("bad_cw_count", 64'(cw_log.size()), 64'd1);
    if (cw_log.size() == 1) begin
      chk("bad_next_ca", 64'(cw_log[0].a), 64'd0);
      chk("bad_next_cd", 64'(cw_log[0].d), 64'h9);
      chk("bad_next_cycle", 64'(cw_log[0].c), 64'(bad + 2));
    end

    // Write presented in the push cycle appears on cw only afterwards.
    cw_log.delete(); push_log.delete();
    for (int i = 0; i < 35; i++) begin
      if (i == 34) k34 = cyc;
      drive(1'b1, 40'(300 + i), 1'b0, '0, '0);
    end
    drive(1'b0, '0, 1'b1, 6'd7, 33'h55);
    idle(3);
    chk("pw_push_cycle", 64'(push_at(0)), 64'(k34 + 1));
    chk("pw_cw_count", 64'(cw_log.size()), 64'd1);
    if (cw_log.size() == 1) begin
      chk("pw_cw_cycle", 64'(cw_log[0].c), 64'(k34 + 2));
      chk("pw_cw_ca", 64'(cw_log[0].a), 64'd7);
    end

    // Reset mid-window discards the partial window and pending writes.
    for (int i = 0; i < 20; i++)
      drive(1'b1, 40'(400 + i), (i == 17 || i == 18), 6'(i - 16), 33'(i));
    cw_log.delete(); push_log.delete();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(5);
    chk("mr_no_push", 64'(push_log.size()), 64'd0);
    chk("mr_no_cw", 64'(cw_log.size()), 64'd0);
    for (int i = 0; i < 35; i++) drive(1'b1, 40'(100 + i), 1'b0, '0, '0);
    idle(3);
    chk("mr_win_cnt", 64'(win_cnt), 64'd1);
    chk("mr_slot0", 64'(last_push_samp[0 +: 40]), 64'd100);
    chk("mr_slot19", 64'(last_push_samp[19*40 +: 40]), 64'd119);
    for (int i = 0; i < 3; i++) begin
      pushout = 1'b1; idle(1);
      pushout = 1'b0; idle(1);
    end
    chk("mr_res_cnt", 64'(res_cnt), 64'd3);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      reset   = ($urandom_range(0, 999) == 0);
      pushout = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 9) < 7, 40'({$urandom(), $urandom()}),
            $urandom_range(0, 9) < 4,
            ($urandom_range(0, 19) == 0) ? 6'($urandom_range(35, 63)) : 6'($urandom_range(0, 34)),
            33'({$urandom(), $urandom()}));
    end
    reset = 1'b0; pushout = 1'b0;
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/c5x7_seq.md
Name: c5x7_seq

Overview:
Front-end sequencer for the c5x7 5x7 convolver. It assembles a 35-sample window from a serial sample stream and queues host coefficient writes. It drives the convolver's ca/cd/cw and push_samp ports so that every weight write accepted before a window completes reaches the convolver before that window is pushed. It also counts pushed windows and returned results for software status.

Parameters:
NTAPS, 35, window size (5 columns x 7 rows, row-major index r*5+c)
SW, 40, sample width (signed)
WW, 33, coefficient data width
AW, 6, coefficient address width
WQ_DEPTH, 4, weight-write queue depth (power of 2)
CNTW, 16, status counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
wv  in  1  host weight write valid
wa  in  AW  host weight address (legal 0..34)
wd  in  WW  host weight data
wrdy  out  1  weight queue can accept (wv&&wrdy = accept)
sv  in  1  sample valid
sd  in  SW  sample, row-major order
srdy  out  1  sequencer can accept sample
ca  out  AW  convolver coefficient address
cd  out  WW  convolver coefficient data
cw  out  1  convolver coefficient write strobe
push_samp  out  1  convolver window push
samp  out  NTAPS*SW  flat window; slot i at [i*SW +: SW]
pushout  in  1  convolver result strobe
win_cnt  out  CNTW  windows pushed (wraps)
res_cnt  out  CNTW  results observed (wraps)
err_addr  out  1  sticky: write with wa>34 seen

Behaviour:
- Reset is synchronous and active-high on clk. Everything is cleared: push_samp=0, cw=0, ca=0, cd=0, samp=0, win_cnt=0, res_cnt=0, err_addr=0, state=FILL, sample index=0, queue empty.
- Asserting reset mid-window discards the partial window and flushes the queue.
- All outputs are registered; none change except on the posedge of clk.
- Weight queue:
  - wrdy = !full.
  - An accepted write with wa>34 is dropped and sets err_addr; it is never enqueued.
  - The head entry drives ca/cd/cw one cycle after it is issued. Minimum latency is accept at cycle t, cw=1 at t+1.
  - At most one write is issued per cycle.
  - When cw=0, ca and cd hold their last values.
- States:
  - FILL:
    - srdy=1. An accepted sample is written into slot idx, then idx++.
    - Queue entries are issued freely.
    - On accepting idx==34, capture fence = number of queue entries after this cycle's enqueue/dequeue. A write accepted in the same cycle as sample 34 counts as before the window.
    - Go to DRAIN if fence>0, else PUSH.
  - DRAIN:
    - srdy=0. Issue only fenced entries, decrementing fence per issue.
    - When fence reaches 0, go to PUSH. Unfenced entries wait.
  - PUSH (one cycle):
    - push_samp=1 with samp stable; cw=0 (writes are never issued in a push cycle).
    - win_cnt++, idx=0, then FILL.
- Timing: with no pending writes, sample 34 accepted at t gives push_samp=1 at t+1 and srdy=1 again at t+2.
- samp holds the previous window's values until overwritten slot by slot. The convolver only samples it at push_samp.
- res_cnt++ on each pushout. Simultaneous increments of both counters are independent.
- Queue full plus wv: no accept and no state change. Queue empty: cw=0.

Decomposition:
- c5x7_pkg: NTAPS, SW, WW, AW, last-address constant 34, and the state enum {FILL, DRAIN, PUSH}.
- One sub-module, c5x7_wq: a synchronous FIFO (WQ_DEPTH x (AW+WW)) with push/pop/full/empty/count.
- The sequencer FSM, window register file and counters stay in c5x7_seq.

Test Plan:
- Reset, then 35 samples sd=i+1 on back-to-back cycles with no writes -> push_samp exactly one cycle after sample 34; slot i = i+1; win_cnt=1; cw never asserted.
- Writes (wa=3,wd=0x1_0000_0005) and (wa=34,wd=0x7) accepted during samples 10 and 34 -> cw pulses with ca=3 then ca=34, both before push_samp; push_samp is delayed by the drain cycles.
- Queue filled with 4 writes and a 5th wv held -> wrdy=0 until the first issue; the 5th write is accepted one cycle later, and all 5 appear on cw in order.
- Write with wa=40 -> err_addr=1 and stays 1; no cw pulse; a following wa=0 write issues normally.
- Write accepted in the PUSH cycle -> cw occurs in the next cycle, not in the push cycle; the next window uses it.
- Reset asserted after 20 samples with 2 writes queued -> no push_samp or cw afterward; the next 35 samples produce a window with win_cnt=1; 3 pushout pulses give res_cnt=3.
